bitrev_dma: RTL and testbench

Bus-initiator engine that copies an N-point block (N = 2^log2n) of 32-bit words from a source region of the data memory to a destination region in bit-reversed index order. This produces the input permutation for the in-place radix-2 FFT. It drives the data-memory port (write enable, address, write data) and consumes its combinational read data. The CPU core or the FFT sequencer triggers it with a one-cycle start and waits for `done`.

---
 rtl/fft_pkg.sv | 16 +
 rtl/bitrev8.sv | 22 ++
 rtl/bitrev_dma.sv | 104 ++++++++++
 tb/tb_bitrev_dma.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath blocks: default widths, size limit and
// the bit-reverse DMA state encoding.
package fft_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 32;
   localparam logic [3:0]  MAX_LOG2N  = 4'd8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      FIN   = 2'd3
   } bitrev_state_t;

endpackage

// File: rtl/bitrev8.sv
// Combinational 8-bit reverse-and-shift: returns the low i_n bits of i_val reversed.
// i_n is expected in 0..8; i_n = 0 yields 0.
module bitrev8 (
   input  logic [7:0] i_val,
   input  logic [3:0] i_n,
   output logic [7:0] o_rev
);

   logic [7:0] w_rev;
   logic [3:0] w_shift;

   always_comb begin
      w_rev = '0;
      for (int b = 0; b < 8; b++) begin
         w_rev[b] = i_val[7-b];
      end
   end

   assign w_shift = 4'd8 - i_n;
   assign o_rev   = w_rev >> w_shift;

endmodule

// File: rtl/bitrev_dma.sv
// Copies an N-point block between memory regions in bit-reversed index order,
// one memory access per cycle (alternating read and write).
module bitrev_dma
   import fft_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        log2n,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   output logic              busy,
   output logic              done,
   output logic              mem_write_en,
   output logic [31:0]       mem_address,
   output logic [DATA_W-1:0] mem_write_DAT,
   input  logic [DATA_W-1:0] mem_read_DAT
);

   bitrev_state_t     r_state;
   logic [8:0]        r_i;
   logic [3:0]        r_n;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [DATA_W-1:0] r_data;

   logic [3:0]        w_n_sat;
   logic [8:0]        w_i_last;
   logic              w_last;
   logic [7:0]        w_rev;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ADDR_W-1:0] w_addr;

   assign w_n_sat  = (log2n > MAX_LOG2N) ? MAX_LOG2N : log2n;
   // 9-bit counter so the last index of a 256-point block is representable
   assign w_i_last = (9'd1 << r_n) - 9'd1;
   assign w_last   = (r_i == w_i_last);

   bitrev8 u_bitrev8 (
      .i_val (r_i[7:0]),
      .i_n   (r_n),
      .o_rev (w_rev)
   );

   assign w_rd_addr = r_src + ADDR_W'(r_i);
   assign w_wr_addr = r_dst + ADDR_W'(w_rev);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_i     <= '0;
         r_n     <= '0;
         r_src   <= '0;
         r_dst   <= '0;
         r_data  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_src   <= src_base;
                  r_dst   <= dst_base;
                  r_n     <= w_n_sat;
                  r_i     <= '0;
                  r_state <= READ;
               end
            end
            READ: begin
               r_data  <= mem_read_DAT;
               r_state <= WRITE;
            end
            WRITE: begin
               if (w_last) begin
                  r_state <= FIN;
               end else begin
                  r_i     <= r_i + 9'd1;
                  r_state <= READ;
               end
            end
            FIN:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      w_addr = '0;
      unique case (r_state)
         READ:    w_addr = w_rd_addr;
         WRITE:   w_addr = w_wr_addr;
         default: w_addr = '0;
      endcase
   end

   assign busy          = (r_state != IDLE);
   assign done          = (r_state == FIN);
   assign mem_write_en  = (r_state == WRITE);
   assign mem_address   = 32'(w_addr);
   assign mem_write_DAT = r_data;

endmodule

// File: tb/tb_bitrev_dma.sv
// Scoreboard bench for bitrev_dma: expected reads/writes are queued by the stimulus
// and popped by a monitor on each memory access.
module tb_bitrev_dma;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  log2n;
   logic [7:0]  src_base;
   logic [7:0]  dst_base;
   logic        busy;
   logic        done;
   logic        mem_write_en;
   logic [31:0] mem_address;
   logic [31:0] mem_write_DAT;
   logic [31:0] mem_read_DAT;

   logic [31:0] mem [256];
   logic [31:0] shadow [256];

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t        wq[$];
   logic [7:0] rq[$];

   int n_checks = 0;
   int n_fail   = 0;

   bitrev_dma #(
      .ADDR_W (8),
      .DATA_W (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .log2n         (log2n),
      .src_base      (src_base),
      .dst_base      (dst_base),
      .busy          (busy),
      .done          (done),
      .mem_write_en  (mem_write_en),
      .mem_address   (mem_address),
      .mem_write_DAT (mem_write_DAT),
      .mem_read_DAT  (mem_read_DAT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_read_DAT = mem[mem_address[7:0]];
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_address[7:0]] <= mem_write_DAT;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] rev_n(input logic [7:0] x, input int n);
      logic [7:0] r;
      r = '0;
      for (int b = 0; b < n; b++) r[n-1-b] = x[b];
      return r;
   endfunction

   // Monitor: every READ/WRITE cycle must match the head of its queue
   always @(negedge clk) begin
      if (!rst && busy && !done) begin
         if (mem_write_en) begin
            if (wq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %0h, none expected", mem_address);
            end else begin
               wr_t e;
               e = wq.pop_front();
               chk("wr_addr", mem_address, {24'h0, e.addr});
               chk("wr_data", mem_write_DAT, e.data);
            end
         end else begin
            if (rq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_read: got addr %0h, none expected", mem_address);
            end else begin
               logic [7:0] a;
               a = rq.pop_front();
               chk("rd_addr", mem_address, {24'h0, a});
            end
         end
      end
   end

   task automatic run_xfer(input logic [3:0] l2n, input logic [7:0] s, input logic [7:0] d,
                           input int exp_done, input bit glitch);
      int cyc;
      bit got;
      @(negedge clk);
      log2n = l2n; src_base = s; dst_base = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      got = 1'b0;
      while (!got && cyc < 1000) begin
         chk("busy_high", {31'h0, busy}, 32'd1);
         if (done) begin
            got = 1'b1;
            chk("done_cycle", 32'(cyc), 32'(exp_done));
         end else begin
            if (glitch && (cyc == 5 || cyc == 10)) begin
               start = 1'b1; src_base = 8'h80; dst_base = 8'h90; log2n = 4'd1;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done after %0d cycles, required cycle %0d", cyc,
                  exp_done);
      end
      @(negedge clk);
      chk("busy_after", {31'h0, busy}, 32'd0);
      chk("done_after", {31'h0, done}, 32'd0);
      chk("rq_empty", 32'(rq.size()), 32'd0);
      chk("wq_empty", 32'(wq.size()), 32'd0);
   endtask

   task automatic setup_n8(input logic [7:0] s, input logic [7:0] d);
      int rev3 [8];
      rev3 = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int k = 0; k < 8; k++) begin
         mem[s+8'(k)] <= 32'hA0 + 32'(k);
         mem[d+8'(k)] <= 32'h0;
         rq.push_back(s + 8'(k));
         wq.push_back('{addr: d + 8'(rev3[k]), data: 32'hA0 + 32'(k)});
      end
   endtask

   task automatic check_n8(input logic [7:0] d);
      logic [31:0] exp8 [8];
      exp8 = '{32'hA0, 32'hA4, 32'hA2, 32'hA6, 32'hA1, 32'hA5, 32'hA3, 32'hA7};
      for (int j = 0; j < 8; j++) chk("n8_mem", mem[d+8'(j)], exp8[j]);
   endtask

   initial begin
      bit seen_done;
      rst = 1'b1; start = 1'b0; log2n = '0; src_base = '0; dst_base = '0;
      for (int k = 0; k < 256; k++) mem[k] = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_we", {31'h0, mem_write_en}, 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_wdat", mem_write_DAT, 32'd0);
      rst = 1'b0;

      // N=8 basic copy
      setup_n8(8'h10, 8'h40);
      run_xfer(4'd3, 8'h10, 8'h40, 17, 1'b0);
      check_n8(8'h40);

      // N=1
      mem[8'h20] <= 32'hDEAD;
      mem[8'h30] <= 32'h0;
      rq.push_back(8'h20);
      wq.push_back('{addr: 8'h30, data: 32'hDEAD});
      run_xfer(4'd0, 8'h20, 8'h30, 3, 1'b0);
      chk("n1_mem", mem[8'h30], 32'hDEAD);

      // Wrap-around with overlapping src/dst: write to 0x00 happens before it is read
      mem[8'hFE] <= 32'h11; mem[8'hFF] <= 32'h22; mem[8'h00] <= 32'h33; mem[8'h01] <= 32'h44;
      rq.push_back(8'hFE); rq.push_back(8'hFF); rq.push_back(8'h00); rq.push_back(8'h01);
      wq.push_back('{addr: 8'hFE, data: 32'h11});
      wq.push_back('{addr: 8'h00, data: 32'h22});
      wq.push_back('{addr: 8'hFF, data: 32'h22});
      wq.push_back('{addr: 8'h01, data: 32'h44});
      run_xfer(4'd2, 8'hFE, 8'hFE, 9, 1'b0);
      chk("wrap_ff", mem[8'hFF], 32'h22);
      chk("wrap_00", mem[8'h00], 32'h22);

      // Start while busy has no effect
      setup_n8(8'h10, 8'h50);
      run_xfer(4'd3, 8'h10, 8'h50, 17, 1'b1);
      check_n8(8'h50);

      // Reset mid-transfer during element 2's WRITE (cycle 6)
      setup_n8(8'h10, 8'h40);
      wq.delete();
      rq.delete();
      for (int k = 0; k < 3; k++) rq.push_back(8'h10 + 8'(k));
      wq.push_back('{addr: 8'h40, data: 32'hA0});
      wq.push_back('{addr: 8'h44, data: 32'hA1});
      @(negedge clk);
      log2n = 4'd3; src_base = 8'h10; dst_base = 8'h40; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rstmid_we", {31'h0, mem_write_en}, 32'd0);
      chk("rstmid_busy", {31'h0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      chk("rstmid_no_done", {31'h0, seen_done}, 32'd0);
      chk("rstmid_rq_empty", 32'(rq.size()), 32'd0);
      chk("rstmid_wq_empty", 32'(wq.size()), 32'd0);
      chk("rstmid_m40", mem[8'h40], 32'hA0);
      chk("rstmid_m44", mem[8'h44], 32'hA1);
      chk("rstmid_m42", mem[8'h42], 32'h0);
      chk("rstmid_m46", mem[8'h46], 32'h0);

      // Fresh start after reset
      setup_n8(8'h10, 8'h40);
      run_xfer(4'd3, 8'h10, 8'h40, 17, 1'b0);
      check_n8(8'h40);

      // Saturation: log2n=9 acts as 8; shadow model tracks the in-order overlap
      for (int k = 0; k < 256; k++) begin
         mem[k] <= 32'h1000 + 32'(k);
         shadow[k] = 32'h1000 + 32'(k);
      end
      for (int k = 0; k < 256; k++) begin
         logic [31:0] v;
         logic [7:0]  wa;
         v  = shadow[k];
         wa = rev_n(8'(k), 8);
         shadow[wa] = v;
         rq.push_back(8'(k));
         wq.push_back('{addr: wa, data: v});
      end
      run_xfer(4'd9, 8'h00, 8'h00, 513, 1'b0);
      chk("sat_m80", mem[8'h80], 32'h1001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
